host_monitor: RTL and testbench

- Synthesizable, parametrised successor of the simulation test-host logic.
- Snoops the core's data-memory write bus and provides three services:
  - a buffered character console stream;
  - pass/fail/tohost exit detection with an exit code;
  - a retirement-based watchdog.
- On a passing exit it dumps a configurable signature window from memory as a word stream.
- Sits beside Pipeline/Memory32 in test tops and FPGA test harnesses.

---
 rtl/host_monitor.sv | 190 +++++++++++++++++++
 tb/tb_host_monitor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_monitor.sv
// Test-host monitor: snoops data-memory writes for console output, exit detection and a
// retirement watchdog, then streams a signature window out of memory after a passing exit.
module host_monitor #(
    parameter logic [31:0]        CHAR_ADDR   = 32'h10000000,
    parameter logic [31:0]        EXIT_ADDR   = 32'h10001000,
    parameter logic [31:0]        TOHOST_ADDR = 32'h00001000,
    parameter logic [7:0]         PASS_CODE   = 8'h03,
    parameter int                 FIFO_DEPTH  = 16,
    parameter int                 DUMP_AW     = 13,
    parameter logic [DUMP_AW-1:0] DUMP_BASE   = DUMP_AW'(32'h1FC0),
    parameter int                 DUMP_WORDS  = 64,
    parameter int                 WDOG_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    input  logic               mem_write,
    input  logic [3:0]         mem_wmask,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    input  logic               retired,
    output logic               char_valid,
    output logic [7:0]         char_data,
    input  logic               char_ready,
    output logic [7:0]         char_drops,
    output logic               dump_req,
    output logic [DUMP_AW-1:0] dump_addr,
    input  logic [31:0]        dump_rdata,
    output logic               dump_valid,
    output logic [31:0]        dump_data,
    output logic               done,
    output logic               pass,
    output logic               timeout,
    output logic [31:0]        exit_code
);

    localparam int FIFO_AW   = $clog2(FIFO_DEPTH);
    localparam int IDX_W     = $clog2(DUMP_WORDS + 1);
    localparam int WDOG_W    = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam int WDOG_LAST = (WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DUMP, S_DONE} state_t;

    state_t state, state_next;

    logic wr_event, ev_char, ev_exit, ev_tohost;
    logic unused_wmask;

    assign wr_event     = mem_valid & mem_write & mem_wmask[0];
    assign ev_char      = wr_event & (mem_addr == CHAR_ADDR);
    assign ev_exit      = wr_event & (mem_addr == EXIT_ADDR);
    assign ev_tohost    = wr_event & (mem_addr == TOHOST_ADDR);
    assign unused_wmask = ^mem_wmask[3:1];

    // Character FIFO; the count carries one extra bit so full and empty differ.
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   fifo_count;
    logic               fifo_empty, fifo_full, push_req, push, pop, drop;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == (FIFO_AW + 1)'(FIFO_DEPTH));
    assign pop        = char_valid & char_ready;
    assign push_req   = ev_char & (state == S_RUN);
    assign push       = push_req & (~fifo_full | pop);
    assign drop       = push_req & fifo_full & ~pop;
    assign char_valid = ~fifo_empty;
    assign char_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            char_drops <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop && char_drops != 8'hFF) begin
                char_drops <= char_drops + 1'b1;
            end
        end
    end

    // Watchdog only runs in RUN; expiry is the edge that would take the count to WDOG_CYCLES.
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_fire;

    assign wdog_fire = (WDOG_CYCLES != 0) && (state == S_RUN) && !retired
                       && (wdog_cnt == WDOG_W'(WDOG_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (state == S_RUN) begin
            if (retired || wdog_fire) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
        end
    end

    // Exit bookkeeping; a bus exit outranks a same-cycle watchdog expiry.
    logic dump_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_code    <= '0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            dump_pending <= 1'b0;
        end else if (state == S_RUN) begin
            if (ev_exit) begin
                exit_code    <= mem_wdata;
                pass         <= (mem_wdata[7:0] == PASS_CODE);
                dump_pending <= (mem_wdata[7:0] == PASS_CODE);
            end else if (ev_tohost) begin
                exit_code    <= mem_wdata;
                pass         <= (mem_wdata == 32'd1);
                dump_pending <= 1'b0;
            end else if (wdog_fire) begin
                timeout <= 1'b1;
            end
        end
    end

    logic [IDX_W-1:0] dump_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_RUN;
            dump_idx   <= '0;
            dump_valid <= 1'b0;
        end else begin
            state      <= state_next;
            dump_valid <= dump_req;
            if (dump_req) begin
                dump_idx <= dump_idx + 1'b1;
            end
        end
    end

    // DUMP stays one cycle past the last request so its read data is still presented there.
    always_comb begin
        state_next = state;
        dump_req   = 1'b0;
        case (state)
            S_RUN: begin
                if (ev_exit || ev_tohost || wdog_fire) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_next = dump_pending ? S_DUMP : S_DONE;
                end
            end
            S_DUMP: begin
                if (dump_idx == IDX_W'(DUMP_WORDS)) begin
                    state_next = S_DONE;
                end else begin
                    dump_req = 1'b1;
                end
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_RUN;
        endcase
    end

    assign done      = (state == S_DONE);
    assign dump_addr = dump_req ? (DUMP_BASE + DUMP_AW'(dump_idx)) : '0;
    assign dump_data = dump_valid ? dump_rdata : 32'h0;

endmodule

// File: tb/tb_host_monitor.sv
// Randomized bench for host_monitor: a queue model of the console FIFO plus directed
// exit, dump, watchdog and reset scenarios.
module tb_host_monitor;

    localparam logic [31:0] CHAR_ADDR   = 32'h10000000;
    localparam logic [31:0] EXIT_ADDR   = 32'h10001000;
    localparam logic [31:0] TOHOST_ADDR = 32'h00001000;
    localparam int          DEPTH       = 16;
    localparam int          DUMP_WORDS  = 64;
    localparam int          DUMP_BASE   = 'h1FC0;
    localparam int          WDOG        = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_write, retired, char_ready;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr, mem_wdata, dump_rdata, dump_data, exit_code;
    logic        char_valid, dump_req, dump_valid, done, pass, timeout;
    logic [7:0]  char_data, char_drops;
    logic [12:0] dump_addr;

    host_monitor #(
        .FIFO_DEPTH (DEPTH),
        .DUMP_WORDS (DUMP_WORDS),
        .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .retired(retired),
        .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
        .char_drops(char_drops), .dump_req(dump_req), .dump_addr(dump_addr),
        .dump_rdata(dump_rdata), .dump_valid(dump_valid), .dump_data(dump_data),
        .done(done), .pass(pass), .timeout(timeout), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory standing in for Memory32 on the dump port.
    logic [31:0] sig_mem [8192];
    always @(posedge clk) dump_rdata <= dump_req ? sig_mem[dump_addr] : $urandom;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] mq[$];
    logic [7:0] got[$];
    int         m_drops;
    bit         m_run;
    int         cyc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic setBus(input logic v, input logic w, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] d);
        mem_valid = v;
        mem_write = w;
        mem_wmask = m;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    task automatic setIdle();
        setBus(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // One clock: advance the FIFO model with the inputs in force, then compare.
    task automatic applyStimulus();
        bit pop, ev_c, ev_x, push;
        pop  = (mq.size() > 0) && char_ready;
        ev_c = m_run && mem_valid && mem_write && mem_wmask[0] && (mem_addr == CHAR_ADDR);
        ev_x = m_run && mem_valid && mem_write && mem_wmask[0]
               && (mem_addr == EXIT_ADDR || mem_addr == TOHOST_ADDR);
        push = ev_c && (mq.size() < DEPTH || pop);
        if (char_valid && char_ready) got.push_back(char_data);
        @(posedge clk);
        #1;
        cyc++;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(mem_wdata[7:0]);
        else if (ev_c && m_drops < 255) m_drops++;
        if (ev_x) m_run = 1'b0;
        checkOutput("char_valid", 32'(char_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) checkOutput("char_data", 32'(char_data), 32'(mq[0]));
        checkOutput("char_drops", 32'(char_drops), m_drops);
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        setBus(1'b1, 1'b1, 4'($urandom) | 4'h1, a, d);
        applyStimulus();
        setIdle();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".char_valid"}, 32'(char_valid), 32'd0);
        checkOutput({tag, ".char_data"},  32'(char_data),  32'd0);
        checkOutput({tag, ".char_drops"}, 32'(char_drops), 32'd0);
        checkOutput({tag, ".dump_req"},   32'(dump_req),   32'd0);
        checkOutput({tag, ".dump_addr"},  32'(dump_addr),  32'd0);
        checkOutput({tag, ".dump_valid"}, 32'(dump_valid), 32'd0);
        checkOutput({tag, ".dump_data"},  dump_data,       32'd0);
        checkOutput({tag, ".done"},       32'(done),       32'd0);
        checkOutput({tag, ".pass"},       32'(pass),       32'd0);
        checkOutput({tag, ".timeout"},    32'(timeout),    32'd0);
        checkOutput({tag, ".exit_code"},  exit_code,       32'd0);
    endtask

    task automatic clearModel();
        mq.delete();
        got.delete();
        m_drops = 0;
        m_run   = 1'b1;
        cyc     = 0;
    endtask

    task automatic doReset(input bit check);
        rst = 1'b1;
        setIdle();
        retired    = 1'b1;
        char_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (check) checkAllZero("reset");
        rst = 1'b0;
        clearModel();
    endtask

    // Non-dumping exit: run long enough to settle and confirm no dump traffic ever appears.
    task automatic runExit(input string tag, input logic [31:0] a, input logic [31:0] d,
                           input logic exp_pass);
        int ndump;
        doReset(1'b0);
        char_ready = 1'b1;
        busWrite(a, d);
        ndump = 0;
        for (int t = 0; t < 100; t++) begin
            applyStimulus();
            if (dump_req || dump_valid) ndump++;
        end
        checkOutput({tag, ".no_dump"},   ndump,           32'd0);
        checkOutput({tag, ".done"},      32'(done),       32'd1);
        checkOutput({tag, ".pass"},      32'(pass),       32'(exp_pass));
        checkOutput({tag, ".exit_code"}, exit_code,       d);
        checkOutput({tag, ".timeout"},   32'(timeout),    32'd0);
    endtask

    task automatic runWatchdog(input string tag, input int pulse_at, input int exp_cycle);
        int first;
        doReset(1'b0);
        retired = 1'b0;
        first = -1;
        for (int t = 0; t < 300 && first < 0; t++) begin
            retired = (cyc + 1 == pulse_at);
            applyStimulus();
            if (timeout) first = cyc;
        end
        retired = 1'b0;
        checkOutput({tag, ".expiry_cycle"}, first, exp_cycle);
        repeat (3) applyStimulus();
        checkOutput({tag, ".done"},      32'(done), 32'd1);
        checkOutput({tag, ".pass"},      32'(pass), 32'd0);
        checkOutput({tag, ".exit_code"}, exit_code, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global time limit");
    end

    initial begin
        logic [7:0]  written [18];
        logic [31:0] d;
        logic [31:0] near [4];
        logic [12:0] exp_addr;
        int          r, nreq, nval, last_val, done_cyc;

        for (int i = 0; i < 8192; i++) sig_mem[i] = $urandom;
        near[0] = EXIT_ADDR + 32'h4;
        near[1] = CHAR_ADDR + 32'h1;
        near[2] = TOHOST_ADDR ^ 32'h8000_0000;
        near[3] = CHAR_ADDR ^ 32'h0100_0000;

        doReset(1'b1);

        // Console: 'H' then 'i', each visible one cycle after its write.
        char_ready = 1'b1;
        d = $urandom;
        d[7:0] = 8'h48;
        busWrite(CHAR_ADDR, d);
        checkOutput("hi.H", 32'(char_data), 32'h48);
        d = $urandom;
        d[7:0] = 8'h69;
        busWrite(CHAR_ADDR, d);
        checkOutput("hi.i", 32'(char_data), 32'h69);
        checkOutput("hi.drops", 32'(char_drops), 32'd0);
        repeat (2) applyStimulus();

        // Overflow: 18 writes into 16 entries with the consumer stalled.
        char_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 18; i++) begin
            d = $urandom;
            written[i] = d[7:0];
            busWrite(CHAR_ADDR, d);
        end
        checkOutput("ovf.drops", 32'(char_drops), 32'd2);
        char_ready = 1'b1;
        for (int t = 0; t < 40 && char_valid; t++) applyStimulus();
        checkOutput("ovf.count", got.size(), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            checkOutput("ovf.order", 32'(got[i]), 32'(written[i]));

        // Random traffic including non-events that must be ignored.
        for (int i = 0; i < 300; i++) begin
            char_ready = ($urandom_range(0, 3) == 0);
            retired    = (i % 10 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            d = $urandom;
            if (r < 5)       setBus(1'b1, 1'b1, 4'($urandom) | 4'h1, CHAR_ADDR, d);
            else if (r == 5) setBus(1'b1, 1'b1, 4'($urandom) & 4'hE, CHAR_ADDR, d);
            else if (r == 6) setBus(1'b0, 1'b1, 4'hF, CHAR_ADDR, d);
            else if (r == 7) setBus(1'b1, 1'b0, 4'hF, CHAR_ADDR, d);
            else if (r == 8) setBus(1'b1, 1'b1, 4'hF, near[$urandom_range(0, 3)], d);
            else             setBus(1'b1, 1'b1, 4'hE, ($urandom_range(0, 1) == 1) ? EXIT_ADDR : TOHOST_ADDR, d);
            applyStimulus();
        end
        setIdle();
        retired = 1'b1;
        checkOutput("rand.done",      32'(done),    32'd0);
        checkOutput("rand.pass",      32'(pass),    32'd0);
        checkOutput("rand.timeout",   32'(timeout), 32'd0);
        checkOutput("rand.exit_code", exit_code,    32'd0);

        // Drop counter saturation.
        char_ready = 1'b0;
        for (int i = 0; i < 290; i++) busWrite(CHAR_ADDR, $urandom);
        checkOutput("sat.drops", 32'(char_drops), 32'd255);
        char_ready = 1'b1;
        for (int t = 0; t < 40 && char_valid; t++) applyStimulus();

        // Passing exit with two bytes still queued, then the signature dump.
        doReset(1'b0);
        busWrite(CHAR_ADDR, $urandom);
        busWrite(CHAR_ADDR, $urandom);
        busWrite(EXIT_ADDR, 32'h3);
        checkOutput("pexit.pass_early", 32'(pass), 32'd1);
        checkOutput("pexit.code_early", exit_code, 32'h3);
        nreq = 0;
        for (int t = 0; t < 5; t++) begin
            applyStimulus();
            if (dump_req) nreq++;
        end
        checkOutput("pexit.no_early_dump", nreq, 32'd0);
        char_ready = 1'b1;
        nreq = 0;
        nval = 0;
        last_val = -1;
        done_cyc = -1;
        for (int t = 0; t < 200 && !done; t++) begin
            applyStimulus();
            if (dump_req) begin
                if (nreq == 0) checkOutput("dump.fifo_empty_first", 32'(char_valid), 32'd0);
                exp_addr = 13'(DUMP_BASE + nreq);
                checkOutput("dump.addr", 32'(dump_addr), 32'(exp_addr));
                nreq++;
            end
            if (dump_valid) begin
                exp_addr = 13'(DUMP_BASE + nval);
                checkOutput("dump.data", dump_data, sig_mem[exp_addr]);
                nval++;
                last_val = cyc;
            end
            if (done) done_cyc = cyc;
        end
        checkOutput("dump.req_count",   nreq,          DUMP_WORDS);
        checkOutput("dump.valid_count", nval,          DUMP_WORDS);
        checkOutput("dump.done_timing", done_cyc,      last_val + 1);
        checkOutput("dump.done",        32'(done),     32'd1);
        checkOutput("dump.pass",        32'(pass),     32'd1);
        checkOutput("dump.exit_code",   exit_code,     32'h3);
        checkOutput("dump.timeout",     32'(timeout),  32'd0);

        // Failing and tohost exits never dump.
        runExit("fail5", EXIT_ADDR, 32'h5, 1'b0);
        d = $urandom;
        if (d[7:0] == 8'h03) d[7:0] = 8'h04;
        runExit("failrnd", EXIT_ADDR, d, 1'b0);
        runExit("tohost1", TOHOST_ADDR, 32'h1, 1'b1);
        runExit("tohost101", TOHOST_ADDR, 32'h101, 1'b0);
        d = $urandom | 32'h2;
        runExit("tohostrnd", TOHOST_ADDR, d, 1'b0);

        // Watchdog: plain expiry, a retire pulse at cycle 50, and an exit on the expiry edge.
        runWatchdog("wdog", -1, 100);
        runWatchdog("wdog_pulse", 50, 150);
        doReset(1'b0);
        retired = 1'b0;
        repeat (99) applyStimulus();
        checkOutput("tie.timeout_before", 32'(timeout), 32'd0);
        busWrite(EXIT_ADDR, 32'h5);
        checkOutput("tie.timeout", 32'(timeout), 32'd0);
        checkOutput("tie.exit_code", exit_code, 32'h5);
        repeat (3) applyStimulus();
        checkOutput("tie.done", 32'(done), 32'd1);
        checkOutput("tie.timeout_after", 32'(timeout), 32'd0);

        // Reset during the 10th dump request.
        doReset(1'b0);
        busWrite(EXIT_ADDR, 32'h3);
        nreq = 0;
        for (int t = 0; t < 50 && nreq < 10; t++) begin
            applyStimulus();
            if (dump_req) nreq++;
        end
        checkOutput("mrst.reached_10th", nreq, 32'd10);
        rst = 1'b1;
        #1;
        checkAllZero("mrst");
        @(posedge clk);
        #1;
        checkOutput("mrst.hold_valid", 32'(dump_valid), 32'd0);
        rst = 1'b0;
        clearModel();
        char_ready = 1'b1;
        nval = 0;
        d = $urandom;
        busWrite(CHAR_ADDR, d);
        checkOutput("mrst.char", 32'(char_data), 32'(d[7:0]));
        for (int t = 0; t < 5; t++) begin
            applyStimulus();
            if (dump_valid || dump_req) nval++;
        end
        checkOutput("mrst.no_dump_after", nval, 32'd0);
        checkOutput("mrst.done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
